// File: rtl/compression_pkg.sv
// Shared constants and types for the IQ frame packer.
package compression_pkg;

  // Two-bit word tags in data_o[31:30]
  localparam logic [1:0] TAG_HDR = 2'b10;
  localparam logic [1:0] TAG_PAY = 2'b01;

  // Width of the frame counter carried in each header word
  localparam int unsigned FRAME_CNT_W = 14;

  // Output framing FSM
  typedef enum logic {
    S_HDR,
    S_PAY
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// A write into a full FIFO is taken only when a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);

  // Pointer update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/iq_frame_packer.sv
// Buffers I/Q pairs from the decimator and emits framed 32-bit words:
// one header word (frame count, frame length) followed by a fixed number of payload words.
module iq_frame_packer
  import compression_pkg::*;
#(
  parameter int unsigned Data_width        = 10,
  parameter int unsigned Samples_per_frame = 1664,
  parameter int unsigned Fifo_depth        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [Data_width-1:0] I_data_i,
  input  logic [Data_width-1:0] Q_data_i,
  input  logic                  data_valid_i,
  output logic [31:0]           data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  overflow_o
);

  localparam int unsigned PairW   = 2 * Data_width;
  localparam logic [15:0] SpfW    = 16'(Samples_per_frame);
  localparam logic [15:0] LastIdx = 16'(Samples_per_frame - 1);
  localparam logic [FRAME_CNT_W-1:0] FrameOne = FRAME_CNT_W'(1);

  state_e                 state_q, state_d;
  logic [15:0]            pay_cnt_q, pay_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   overflow_q;

  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [PairW-1:0] fifo_rdata;
  logic [29:0]      pay_body;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign fifo_push  = data_valid_i && (!fifo_full || fifo_pop);
  assign overflow_o = overflow_q;

  sync_fifo #(
    .Width (PairW),
    .Depth (Fifo_depth)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (fifo_push),
    .wr_data_i ({Q_data_i, I_data_i}),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Next-state and output decode; outputs are zero whenever nothing is offered
  always_comb begin
    state_d      = state_q;
    pay_cnt_d    = pay_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    data_valid_o = 1'b0;
    data_o       = '0;
    sof_o        = 1'b0;
    eof_o        = 1'b0;
    fifo_pop     = 1'b0;
    pay_body     = '0;
    pay_body[PairW-1:0] = fifo_rdata;

    unique case (state_q)
      // Header is only offered once a pair is waiting, so a frame never starts empty
      S_HDR: begin
        if (!fifo_empty) begin
          data_valid_o = 1'b1;
          data_o       = {TAG_HDR, frame_cnt_q, SpfW};
          sof_o        = 1'b1;
          if (data_ready_i) state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (!fifo_empty) begin
          data_valid_o = 1'b1;
          data_o       = {TAG_PAY, pay_body};
          eof_o        = (pay_cnt_q == LastIdx);
          if (data_ready_i) begin
            fifo_pop = 1'b1;
            if (pay_cnt_q == LastIdx) begin
              pay_cnt_d   = '0;
              frame_cnt_d = frame_cnt_q + FrameOne;
              state_d     = S_HDR;
            end else begin
              pay_cnt_d = pay_cnt_q + 16'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // State, counters and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_HDR;
      pay_cnt_q   <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pay_cnt_q   <= pay_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      if (data_valid_i && !fifo_push) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
// Self-checking bench for iq_frame_packer: a queue-based reference model predicts every
// output word; a second instance with one-pair frames exercises the frame counter wrap.
module tb_iq_frame_packer;

  localparam int Spf   = 4;
  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  i_data = '0, q_data = '0;
  logic        vin = 1'b0, rdy = 1'b0;
  logic [31:0] dout;
  logic        vout, sof, eof, ovf;

  logic [9:0]  i2 = '0, q2 = '0;
  logic        vin2 = 1'b0, rdy2 = 1'b1;
  logic [31:0] dout2;
  logic        vout2, sof2, eof2, ovf2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [19:0] m_q[$];
  bit          m_hdr = 1'b1;
  int          m_pidx = 0;
  int          m_fcnt = 0;
  bit          m_ovf = 1'b0;

  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_eof, prev_sof;

  always #5 clk = ~clk;

  iq_frame_packer #(
    .Data_width        (10),
    .Samples_per_frame (Spf),
    .Fifo_depth        (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .I_data_i     (i_data),
    .Q_data_i     (q_data),
    .data_valid_i (vin),
    .data_o       (dout),
    .data_valid_o (vout),
    .data_ready_i (rdy),
    .sof_o        (sof),
    .eof_o        (eof),
    .overflow_o   (ovf)
  );

  iq_frame_packer #(
    .Data_width        (10),
    .Samples_per_frame (1),
    .Fifo_depth        (Depth)
  ) dut_wrap (
    .clk_i        (clk),
    .rst_i        (rst),
    .I_data_i     (i2),
    .Q_data_i     (q2),
    .data_valid_i (vin2),
    .data_o       (dout2),
    .data_valid_o (vout2),
    .data_ready_i (rdy2),
    .sof_o        (sof2),
    .eof_o        (eof2),
    .overflow_o   (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    vin  = 1'b0;
    rdy  = 1'b0;
    vin2 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_hdr      = 1'b1;
    m_pidx     = 0;
    m_fcnt     = 0;
    m_ovf      = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model
  task automatic step(input logic push, input logic [9:0] i, input logic [9:0] q,
                      input logic ready);
    logic [31:0] exp_d;
    logic        exp_v, exp_s, exp_e;
    bit          xfer, pop, acc;
    vin = push; i_data = i; q_data = q; rdy = ready;
    @(negedge clk);
    exp_v = (m_q.size() > 0);
    exp_d = '0; exp_s = 1'b0; exp_e = 1'b0;
    if (exp_v) begin
      if (m_hdr) begin
        exp_d = {2'b10, 14'(m_fcnt), 16'(Spf)};
        exp_s = 1'b1;
      end else begin
        exp_d = {2'b01, 10'b0, m_q[0]};
        exp_e = (m_pidx == Spf - 1);
      end
    end
    check("valid", 32'(vout), 32'(exp_v));
    check("data", dout, exp_d);
    check("sof", 32'(sof), 32'(exp_s));
    check("eof", 32'(eof), 32'(exp_e));
    check("overflow", 32'(ovf), 32'(m_ovf));
    if (prev_stall) begin
      check("stall_data", dout, prev_data);
      check("stall_eof", 32'(eof), 32'(prev_eof));
      check("stall_sof", 32'(sof), 32'(prev_sof));
    end
    prev_stall = exp_v && !ready;
    prev_data  = dout;
    prev_eof   = eof;
    prev_sof   = sof;

    xfer = exp_v && ready;
    pop  = xfer && !m_hdr;
    acc  = push && ((m_q.size() < Depth) || pop);
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back({q, i});
    if (push && !acc) m_ovf = 1'b1;
    if (xfer) begin
      if (m_hdr) begin
        m_hdr = 1'b0;
      end else if (m_pidx == Spf - 1) begin
        m_pidx = 0;
        m_fcnt = (m_fcnt + 1) % 16384;
        m_hdr  = 1'b1;
      end else begin
        m_pidx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 10'd0, 10'd0, 1'b1);
  endtask

  initial begin
    int hdr_seen;
    bit saw_wrap;

    // Basic frame: I=1..4, Q=-1..-4
    apply_reset();
    step(1'b1, 10'd1, 10'(-1), 1'b1);
    check("hdr_first", dout, 32'h8000_0004);
    check("hdr_first_sof", 32'(sof), 32'd1);
    for (int k = 2; k <= 4; k++) step(1'b1, 10'(k), 10'(-k), 1'b1);
    drain(8);

    // Twelve pushes -> three frames
    apply_reset();
    for (int k = 0; k < 12; k++) step(1'b1, 10'($urandom), 10'($urandom), 1'b1);
    drain(12);
    check("three_frames", 32'(m_fcnt), 32'd3);

    // Full FIFO, simultaneous push and pop
    apply_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 10'(k + 20), 10'(k + 40), 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b1);
    step(1'b1, 10'd77, 10'd88, 1'b1);
    check("full_pushpop_ovf", 32'(ovf), 32'd0);
    drain(10);

    // Overflow with a stalled sink
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 10'(k), 10'(k + 100), 1'b0);
      if (k == 4) check("ovf_after4", 32'(ovf), 32'd0);
      if (k == 5) check("ovf_after5", 32'(ovf), 32'd1);
    end
    drain(10);

    // Random push/ready traffic
    apply_reset();
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
           1'($urandom_range(0, 9) < 6));
    drain(20);

    // Reset in the middle of a frame
    apply_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 10'(k), 10'(k + 8), 1'b1);
    check("mid_frame_pidx", 32'(m_pidx), 32'd2);
    apply_reset();
    check("rst_valid", 32'(vout), 32'd0);
    check("rst_data", dout, 32'd0);
    check("rst_sof", 32'(sof), 32'd0);
    check("rst_eof", 32'(eof), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    step(1'b1, 10'd5, 10'd6, 1'b1);
    check("post_rst_hdr", dout, 32'h8000_0004);
    drain(8);

    // Frame counter wrap on the one-pair-per-frame instance
    apply_reset();
    hdr_seen = 0;
    saw_wrap = 1'b0;
    for (int c = 0; c < 2 * (16384 + 4); c++) begin
      vin2 = (c % 2 == 0);
      i2   = 10'(c);
      q2   = 10'(c >> 1);
      @(negedge clk);
      if (vout2) begin
        if (sof2) begin
          if (hdr_seen == 16384) begin
            check("wrap_hdr", dout2, {2'b10, 14'd0, 16'd1});
            saw_wrap = 1'b1;
          end else if (hdr_seen == 16383 || hdr_seen < 3) begin
            check("hdr_cnt", dout2, {2'b10, 14'(hdr_seen), 16'd1});
          end
          hdr_seen++;
        end else if (hdr_seen < 3) begin
          check("spf1_eof", 32'(eof2), 32'd1);
        end
      end
      @(posedge clk);
      #1;
    end
    vin2 = 1'b0;
    check("wrap_seen", 32'(saw_wrap), 32'd1);
    check("wrap_no_ovf", 32'(ovf2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
